// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, with a fast path for divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                a_signed, b_signed, in_neg_a, in_neg_b;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                is_div_in, div_by_zero, sgn_overflow, fast_path;
  logic [XLEN-1:0]     fast_value;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_wide;
  logic                rem_geq;
  logic [XLEN-1:0]     rem_diff;
  logic [2*XLEN-1:0]   prod_fixed;
  logic [XLEN-1:0]     quot_fixed, rem_fixed, fix_value;

  assign accept = start_i && !kill_i && (state_q == IDLE || state_q == DONE);

  // MULH, DIV and REM treat both operands as signed; MULHSU only op_a.
  assign a_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign b_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                     (funct3_i == 3'b110);
  assign in_neg_a  = a_signed && op_a_i[XLEN-1];
  assign in_neg_b  = b_signed && op_b_i[XLEN-1];
  assign abs_a     = in_neg_a ? (~op_a_i + 1'b1) : op_a_i;
  assign abs_b     = in_neg_b ? (~op_b_i + 1'b1) : op_b_i;

  assign is_div_in    = funct3_i[2];
  assign div_by_zero  = is_div_in && (op_b_i == '0);
  assign sgn_overflow = is_div_in && !funct3_i[0] &&
                        (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  assign fast_path    = div_by_zero || sgn_overflow;

  always_comb begin
    fast_value = '0;
    if (div_by_zero)
      fast_value = funct3_i[1] ? op_a_i : '1;
    else if (sgn_overflow)
      fast_value = funct3_i[1] ? '0 : op_a_i;
  end

  // Multiply: add multiplicand into the upper half, keep the carry for the shift.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: shifted remainder needs XLEN+1 bits before the compare.
  assign rem_wide = acc_q[2*XLEN-1:XLEN-1];
  assign rem_geq  = rem_wide >= {1'b0, opnd_q};
  assign rem_diff = rem_wide[XLEN-1:0] - opnd_q;

  assign prod_fixed = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
  assign quot_fixed = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fixed  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_value = prod_fixed[XLEN-1:0];
    case (funct3_q)
      3'b000:                 fix_value = prod_fixed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_value = prod_fixed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_value = quot_fixed;
      default:                fix_value = rem_fixed;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)
          state_d = fast_path ? DONE : RUN;
        else
          state_d = IDLE;
      end
      RUN: begin
        if (kill_i)
          state_d = IDLE;
        else if (cnt_q == CW'(XLEN-1))
          state_d = FIX;
      end
      FIX:     state_d = kill_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      cnt_d    = '0;
      funct3_d = funct3_i;
      neg_a_d  = in_neg_a;
      neg_b_d  = in_neg_b;
      opnd_d   = is_div_in ? abs_b : abs_a;
      acc_d    = {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
      if (fast_path)
        result_d = fast_value;
    end else if (state_q == RUN && !kill_i) begin
      cnt_d = cnt_q + 1'b1;
      if (funct3_q[2])
        acc_d = {(rem_geq ? rem_diff : rem_wide[XLEN-1:0]), acc_q[XLEN-2:0], rem_geq};
      else
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end else if (state_q == FIX && !kill_i) begin
      result_d = fix_value;
    end
  end

  always_comb begin
    busy_o   = (state_q == RUN) || (state_q == FIX);
    done_o   = (state_q == DONE);
    stall_o  = busy_o || accept;
    result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: normal and fast paths,
// kill, back-to-back issue, ignored starts and asynchronous reset.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int compared   = 0;
  int mismatched = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic kl, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b);
    start_i  = st;
    kill_i   = kl;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
  endtask

  // Drive a request in the current cycle (cycle 0) and check it stalls.
  task automatic issue(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, 1'b0, f3, a, b);
    #1;
    checkOutput({tag, " stall0"}, {31'd0, stall_o}, 32'd1);
  endtask

  // Step cycles until done; optionally toggle start/operands while busy.
  task automatic waitDone(input string tag, input int expLat, input logic [31:0] expRes,
                          input logic expBusy, input bit toggle);
    int lat = 0;
    int bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      if (toggle)
        applyStimulus((c % 2) == 1, 1'b0, 3'b000, 32'(c), 32'(c * 3));
      else
        start_i = 1'b0;
      #1;
      if (done_o === 1'b1) begin
        lat = c;
        break;
      end
      if (stall_o !== 1'b1 || busy_o !== expBusy) bad++;
    end
    start_i = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, result_o, expRes);
    checkOutput({tag, " stall/busy while running"}, 32'(bad), 32'd0);
    checkOutput({tag, " stall+busy at done"}, {30'd0, stall_o, busy_o}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk_i);
    issue(tag, f3, a, b);
    waitDone(tag, expLat, expRes, expLat > 1, 1'b0);
  endtask

  initial begin
    int bad;
    reset_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #12;
    checkOutput("reset outputs", {29'd0, busy_o, stall_o, done_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    $display("[TB] multiply");
    runOp("mul 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    runOp("mulh min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    runOp("mulhu 2^31*2^31", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    runOp("mulhsu -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);

    $display("[TB] divide");
    runOp("div -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    runOp("rem -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    runOp("divu 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       34);

    $display("[TB] back-to-back issue in DONE");
    issue("remu b2b", 3'b111, 32'd100, 32'd7);
    waitDone("remu b2b", 34, 32'd2, 1'b1, 1'b0);

    $display("[TB] fast path");
    runOp("divu 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    runOp("rem 5/0",         3'b110, 32'd5,        32'd0,        32'd5,        1);
    runOp("div overflow",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("rem overflow",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    $display("[TB] kill in cycle 10");
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk_i);
    issue("kill div", 3'b100, 32'hFFFFFFF9, 32'd2);
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (c == 10) kill_i = 1'b1;
      #1;
      if (done_o !== 1'b0) bad++;
    end
    @(negedge clk_i);
    kill_i = 1'b0;
    #1;
    checkOutput("kill no done", 32'(bad), 32'd0);
    checkOutput("kill idle flags", {30'd0, busy_o, done_o}, 32'd0);
    checkOutput("kill result held", result_o, 32'd0);
    issue("mul after kill", 3'b000, 32'd3, 32'd4);
    waitDone("mul after kill", 34, 32'd12, 1'b1, 1'b0);

    $display("[TB] start toggled while busy");
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk_i);
    issue("divu toggled", 3'b101, 32'd100, 32'd7);
    waitDone("divu toggled", 34, 32'd14, 1'b1, 1'b1);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk_i);
    issue("reset run", 3'b000, 32'd9, 32'd9);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #1;
    checkOutput("busy before reset", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    checkOutput("mid-run reset flags", {29'd0, busy_o, stall_o, done_o}, 32'd0);
    checkOutput("mid-run reset result", result_o, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    checkOutput("after reset idle", {30'd0, busy_o, done_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
